// File: rtl/cc_pkg.sv
// Shared cache-controller definitions: miss address slicing, AXI read-burst
// constants and the miss request FSM state type.
package cc_pkg;

  localparam int unsigned ADDR_W = 32;

  // Miss byte address layout: tag | index | word | byte
  localparam int unsigned TAG_MSB  = 31;
  localparam int unsigned TAG_LSB  = 15;
  localparam int unsigned IDX_MSB  = 14;
  localparam int unsigned IDX_LSB  = 6;
  localparam int unsigned WORD_MSB = 5;
  localparam int unsigned WORD_LSB = 3;

  // AXI read burst shape for one 64-byte line
  localparam logic [1:0]  AXI_BURST_WRAP = 2'b10;
  localparam logic [2:0]  AXI_SIZE_8B    = 3'b011;
  localparam int unsigned LINE_BEATS     = 8;

  typedef enum logic {
    S_IDLE,
    S_REQ
  } miss_state_t;

  // Critical-word address: keep tag/index/word, clear the byte offset.
  function automatic logic [ADDR_W-1:0] crit_word_addr(
    input logic [TAG_MSB:WORD_LSB] word_addr
  );
    return {word_addr[TAG_MSB:TAG_LSB],
            word_addr[IDX_MSB:IDX_LSB],
            word_addr[WORD_MSB:WORD_LSB],
            3'b000};
  endfunction

endpackage

// File: rtl/cc_miss_request_unit_if.sv
// Miss request unit bus bundle: pipeline miss handshake, miss-address FIFO
// push port, AXI AR channel, R-channel retire monitor and busy flag.
// Signal suffixes are relative to the miss request unit.
//   master : the miss request unit
//   slave  : its environment (pipeline, FIFO, memory)
interface cc_miss_request_unit_if
  import cc_pkg::*;
#(
  parameter int unsigned ID_W = 4
);

  // Pipeline miss handshake
  logic              miss_valid_i;
  logic [ADDR_W-1:0] miss_addr_i;
  logic              miss_ready_o;

  // Miss-address FIFO push port
  logic              miss_addr_fifo_full_i;
  logic              miss_addr_fifo_wren_o;
  logic [ADDR_W-1:0] miss_addr_fifo_wdata_o;

  // AXI AR channel
  logic [ID_W-1:0]   mem_arid_o;
  logic [ADDR_W-1:0] mem_araddr_o;
  logic [3:0]        mem_arlen_o;
  logic [2:0]        mem_arsize_o;
  logic [1:0]        mem_arburst_o;
  logic              mem_arvalid_o;
  logic              mem_arready_i;

  // AXI R channel monitor
  logic              mem_rvalid_i;
  logic              mem_rready_i;
  logic              mem_rlast_i;

  logic              busy_o;

  modport master (
    input  miss_valid_i, miss_addr_i, miss_addr_fifo_full_i,
           mem_arready_i, mem_rvalid_i, mem_rready_i, mem_rlast_i,
    output miss_ready_o, miss_addr_fifo_wren_o, miss_addr_fifo_wdata_o,
           mem_arid_o, mem_araddr_o, mem_arlen_o, mem_arsize_o,
           mem_arburst_o, mem_arvalid_o, busy_o
  );

  modport slave (
    output miss_valid_i, miss_addr_i, miss_addr_fifo_full_i,
           mem_arready_i, mem_rvalid_i, mem_rready_i, mem_rlast_i,
    input  miss_ready_o, miss_addr_fifo_wren_o, miss_addr_fifo_wdata_o,
           mem_arid_o, mem_araddr_o, mem_arlen_o, mem_arsize_o,
           mem_arburst_o, mem_arvalid_o, busy_o
  );

endinterface

// File: rtl/cc_miss_request_unit.sv
// Cache-controller miss request unit. Accepts misses from the tag-compare
// pipeline, pushes the miss address into the miss-address FIFO and issues
// one 64-byte critical-word-first WRAP read burst per miss on AXI AR.
// Bounds line fills in flight to MAX_OUTSTANDING and back-pressures the
// pipeline.
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : cc_miss_request_unit_if.master (miss handshake, FIFO push,
//           AR channel, R retire monitor, busy_o)
module cc_miss_request_unit
  import cc_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned ID_W            = 4,
  parameter int unsigned AR_ID           = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cc_miss_request_unit_if.master bus
);

  localparam int unsigned      CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  miss_state_t       state_q, state_d;
  logic              arvalid_q, arvalid_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [CNT_W-1:0]  count_q;

  logic ready_c;
  logic accept_c;
  logic retire_c;

  // Ready only in IDLE with FIFO room and fill budget; held low during reset.
  assign ready_c  = rst_n && (state_q == S_IDLE) &&
                    !bus.miss_addr_fifo_full_i && (count_q < CNT_MAX);
  assign accept_c = bus.miss_valid_i && ready_c;

  // Last R beat retires a fill; a stray retire with nothing in flight is ignored.
  assign retire_c = bus.mem_rvalid_i && bus.mem_rready_i && bus.mem_rlast_i &&
                    (count_q != '0);

  // Next-state / AR request logic
  always_comb begin
    state_d   = state_q;
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          state_d   = S_REQ;
          arvalid_d = 1'b1;
          araddr_d  = crit_word_addr(bus.miss_addr_i[TAG_MSB:WORD_LSB]);
        end
      end
      S_REQ: begin
        // Address held until the slave takes it; arready only affects the next edge.
        if (bus.mem_arready_i) begin
          state_d   = S_IDLE;
          arvalid_d = 1'b0;
        end
      end
      default: begin
        state_d   = S_IDLE;
        arvalid_d = 1'b0;
      end
    endcase
  end

  // FSM and AR register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
    end else begin
      state_q   <= state_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
    end
  end

  // Outstanding fill counter; simultaneous accept and retire cancel out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      unique case ({accept_c, retire_c})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Pipeline and FIFO side
  assign bus.miss_ready_o           = ready_c;
  assign bus.miss_addr_fifo_wren_o  = accept_c;
  assign bus.miss_addr_fifo_wdata_o = accept_c ? bus.miss_addr_i : '0;

  // AR channel
  assign bus.mem_arid_o    = ID_W'(AR_ID);
  assign bus.mem_araddr_o  = araddr_q;
  assign bus.mem_arlen_o   = 4'(LINE_BEATS - 1);
  assign bus.mem_arsize_o  = AXI_SIZE_8B;
  assign bus.mem_arburst_o = AXI_BURST_WRAP;
  assign bus.mem_arvalid_o = arvalid_q;

  assign bus.busy_o = (count_q != '0);

endmodule

// File: tb/tb_cc_miss_request_unit.sv
// Self-checking bench for cc_miss_request_unit: directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_cc_miss_request_unit;
  import cc_pkg::*;

  localparam int unsigned MAX_OUT = 2;
  localparam int unsigned TB_ID_W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cc_miss_request_unit_if #(.ID_W(TB_ID_W)) bus ();

  cc_miss_request_unit #(
    .MAX_OUTSTANDING(MAX_OUT),
    .ID_W           (TB_ID_W),
    .AR_ID          (0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: fills in flight, pending AR, and logs of pushes / issued ARs
  int          m_out       = 0;
  bit          m_pend      = 1'b0;
  logic [31:0] m_pend_addr = '0;
  logic [31:0] m_push_log[$];
  logic [31:0] m_ar_log[$];
  logic [31:0] obs_push[$];
  logic [31:0] obs_ar[$];
  logic        exp_ready;

  assign exp_ready = rst_n && !m_pend && !bus.miss_addr_fifo_full_i && (m_out < int'(MAX_OUT));

  always @(posedge clk) begin
    if (!rst_n) begin
      m_out  <= 0;
      m_pend <= 1'b0;
    end else begin
      if (m_pend && bus.mem_arready_i) begin
        m_pend <= 1'b0;
        m_ar_log.push_back(m_pend_addr);
      end
      if (bus.miss_valid_i && exp_ready) begin
        m_pend      <= 1'b1;
        m_pend_addr <= bus.miss_addr_i & ~32'h7;
        m_push_log.push_back(bus.miss_addr_i);
      end
      m_out <= m_out + ((bus.miss_valid_i && exp_ready) ? 1 : 0)
                     - ((bus.mem_rvalid_i && bus.mem_rready_i && bus.mem_rlast_i && m_out > 0) ? 1 : 0);
    end
  end

  // Observed FIFO pushes and AR handshakes, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.miss_addr_fifo_wren_o) obs_push.push_back(bus.miss_addr_fifo_wdata_o);
      if (bus.mem_arvalid_o && bus.mem_arready_i) obs_ar.push_back(bus.mem_araddr_o);
    end
  end

  task automatic drive(input logic v, input logic [31:0] a, input logic full,
                       input logic arr, input logic rb);
    bus.miss_valid_i          = v;
    bus.miss_addr_i           = a;
    bus.miss_addr_fifo_full_i = full;
    bus.mem_arready_i         = arr;
    bus.mem_rvalid_i          = rb;
    bus.mem_rready_i          = rb;
    bus.mem_rlast_i           = rb;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(1'b1, 32'hdead_beef, 1'b0, 1'b1, 1'b1);
    next_cycle();
    next_cycle();
    @(negedge clk);
    n_tests++; if (bus.mem_arvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_arvalid got %b exp 0", bus.mem_arvalid_o); end
    n_tests++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", bus.busy_o); end
    n_tests++; if (bus.miss_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b exp 0", bus.miss_ready_o); end
    n_tests++; if (bus.miss_addr_fifo_wren_o !== 1'b0) begin n_fail++; $display("FAIL reset_wren got %b exp 0", bus.miss_addr_fifo_wren_o); end
    n_tests++; if (bus.mem_araddr_o !== 32'h0) begin n_fail++; $display("FAIL reset_araddr got %h exp 0", bus.mem_araddr_o); end
    n_tests++; if (bus.mem_arid_o !== 4'd0) begin n_fail++; $display("FAIL reset_arid got %h exp 0", bus.mem_arid_o); end
    n_tests++; if (bus.mem_arlen_o !== 4'd7) begin n_fail++; $display("FAIL reset_arlen got %0d exp 7", bus.mem_arlen_o); end
    n_tests++; if (bus.mem_arsize_o !== 3'b011) begin n_fail++; $display("FAIL reset_arsize got %b exp 011", bus.mem_arsize_o); end
    n_tests++; if (bus.mem_arburst_o !== 2'b10) begin n_fail++; $display("FAIL reset_arburst got %b exp 10", bus.mem_arburst_o); end
    next_cycle();
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_tests++; if (bus.miss_ready_o !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready got %b exp 1", bus.miss_ready_o); end
    next_cycle();
  endtask

  task automatic test_single_miss;
    drive(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_tests++; if (bus.miss_ready_o !== 1'b1) begin n_fail++; $display("FAIL single_ready got %b exp 1", bus.miss_ready_o); end
    n_tests++; if (bus.miss_addr_fifo_wren_o !== 1'b1) begin n_fail++; $display("FAIL single_wren got %b exp 1", bus.miss_addr_fifo_wren_o); end
    n_tests++; if (bus.miss_addr_fifo_wdata_o !== 32'h1234_5678) begin n_fail++; $display("FAIL single_wdata got %h exp 12345678", bus.miss_addr_fifo_wdata_o); end
    n_tests++; if (bus.mem_arvalid_o !== 1'b0) begin n_fail++; $display("FAIL single_arvalid_early got %b exp 0", bus.mem_arvalid_o); end
    next_cycle();
    // arready on the third REQ cycle: arvalid high for exactly three cycles
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 32'h0, 1'b0, (k == 2), 1'b0);
      @(negedge clk);
      n_tests++; if (bus.mem_arvalid_o !== (k < 3)) begin n_fail++; $display("FAIL single_arvalid k=%0d got %b exp %b", k, bus.mem_arvalid_o, (k < 3)); end
      if (k < 3) begin
        n_tests++;
        if (bus.mem_araddr_o !== 32'h1234_5678 || bus.mem_arlen_o !== 4'd7 ||
            bus.mem_arsize_o !== 3'b011 || bus.mem_arburst_o !== 2'b10) begin
          n_fail++;
          $display("FAIL single_ar_fields k=%0d got addr %h len %0d size %b burst %b exp 12345678/7/011/10",
                   k, bus.mem_araddr_o, bus.mem_arlen_o, bus.mem_arsize_o, bus.mem_arburst_o);
        end
        n_tests++; if (bus.miss_ready_o !== 1'b0) begin n_fail++; $display("FAIL single_ready_req k=%0d got %b exp 0", k, bus.miss_ready_o); end
      end
      n_tests++; if (bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL single_busy k=%0d got %b exp 1", k, bus.busy_o); end
      next_cycle();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_tests++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL single_busy_retired got %b exp 0", bus.busy_o); end
    next_cycle();
  endtask

  task automatic test_back_to_back;
    int          accepts = 0;
    logic [31:0] addr;
    for (int c = 0; c < 6; c++) begin
      addr = 32'h0100_0005 + (32'(accepts) << 6);
      drive(1'b1, addr, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      if (bus.miss_addr_fifo_wren_o === 1'b1) begin
        accepts++;
        n_tests++; if (bus.miss_addr_fifo_wdata_o !== addr) begin n_fail++; $display("FAIL b2b_wdata c=%0d got %h exp %h", c, bus.miss_addr_fifo_wdata_o, addr); end
      end
      next_cycle();
    end
    n_tests++; if (accepts != 2) begin n_fail++; $display("FAIL b2b_accepts got %0d exp 2", accepts); end
    addr = 32'h0100_0005 + (32'(accepts) << 6);
    drive(1'b1, addr, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    n_tests++; if (bus.miss_ready_o !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_at_max got %b exp 0", bus.miss_ready_o); end
    n_tests++; if (bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL b2b_busy got %b exp 1", bus.busy_o); end
    next_cycle();
    drive(1'b1, addr, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    n_tests++; if (bus.miss_ready_o !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_retire_cycle got %b exp 0", bus.miss_ready_o); end
    next_cycle();
    drive(1'b1, addr, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    n_tests++;
    if (bus.miss_ready_o !== 1'b1 || bus.miss_addr_fifo_wren_o !== 1'b1 || bus.miss_addr_fifo_wdata_o !== addr) begin
      n_fail++;
      $display("FAIL b2b_third_accept got ready %b wren %b data %h exp 1 1 %h",
               bus.miss_ready_o, bus.miss_addr_fifo_wren_o, bus.miss_addr_fifo_wdata_o, addr);
    end
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    n_tests++; if (bus.mem_araddr_o !== (addr & ~32'h7)) begin n_fail++; $display("FAIL b2b_third_araddr got %h exp %h", bus.mem_araddr_o, addr & ~32'h7); end
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    next_cycle();
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_tests++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL b2b_drained_busy got %b exp 0", bus.busy_o); end
    next_cycle();
  endtask

  task automatic test_fifo_full;
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 32'hABCD_0004, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      n_tests++;
      if (bus.miss_ready_o !== 1'b0 || bus.miss_addr_fifo_wren_o !== 1'b0 || bus.mem_arvalid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL full_block c=%0d got ready %b wren %b arvalid %b exp 0 0 0",
                 c, bus.miss_ready_o, bus.miss_addr_fifo_wren_o, bus.mem_arvalid_o);
      end
      next_cycle();
    end
    drive(1'b1, 32'hABCD_0004, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    n_tests++; if (bus.miss_addr_fifo_wren_o !== 1'b1) begin n_fail++; $display("FAIL full_release_accept got %b exp 1", bus.miss_addr_fifo_wren_o); end
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    n_tests++;
    if (bus.mem_arvalid_o !== 1'b1 || bus.mem_araddr_o !== 32'hABCD_0000) begin
      n_fail++;
      $display("FAIL full_ar got arvalid %b addr %h exp 1 abcd0000", bus.mem_arvalid_o, bus.mem_araddr_o);
    end
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_tests++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL full_drained_busy got %b exp 0", bus.busy_o); end
    next_cycle();
  endtask

  task automatic test_reset_mid_burst;
    drive(1'b1, 32'h0000_2008, 1'b0, 1'b0, 1'b0);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.mem_arvalid_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_arvalid got %b exp 1", bus.mem_arvalid_o); end
    next_cycle();
    @(negedge clk);
    n_tests++; if (bus.mem_arvalid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_arvalid got %b exp 0", bus.mem_arvalid_o); end
    n_tests++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b exp 0", bus.busy_o); end
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.miss_ready_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got %b exp 1", bus.miss_ready_o); end
    next_cycle();
  endtask

  task automatic test_count_limit;
    // Steps: stray retire at zero, fill to max, retire, accept+retire together, refill to max
    bit tv[11]       = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    bit trb[11]      = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    bit texp_rdy[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    bit texp_bsy[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic v;
    for (int s = 0; s < 11; s++) begin
      drive(tv[s], $urandom, 1'b0, 1'b1, trb[s]);
      @(negedge clk);
      n_tests++; if (bus.miss_ready_o !== texp_rdy[s]) begin n_fail++; $display("FAIL limit_ready step %0d got %b exp %b", s, bus.miss_ready_o, texp_rdy[s]); end
      n_tests++; if (bus.busy_o !== texp_bsy[s]) begin n_fail++; $display("FAIL limit_busy step %0d got %b exp %b", s, bus.busy_o, texp_bsy[s]); end
      next_cycle();
    end
    for (int i = 0; i < 10; i++) begin
      v = 1'($urandom_range(0, 1));
      drive(v, $urandom, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      @(negedge clk);
      n_tests++; if (bus.miss_ready_o !== exp_ready) begin n_fail++; $display("FAIL limit_rand_ready i=%0d got %b exp %b", i, bus.miss_ready_o, exp_ready); end
      n_tests++; if (bus.busy_o !== (m_out != 0)) begin n_fail++; $display("FAIL limit_rand_busy i=%0d got %b exp %b", i, bus.busy_o, (m_out != 0)); end
      n_tests++; if (m_out >= int'(MAX_OUT) && bus.miss_ready_o !== 1'b0) begin n_fail++; $display("FAIL limit_overflow i=%0d got ready %b exp 0", i, bus.miss_ready_o); end
      next_cycle();
    end
  endtask

  task automatic test_random;
    logic v;
    int   n;
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    rst_n = 1'b1;
    obs_push.delete();
    obs_ar.delete();
    m_push_log.delete();
    m_ar_log.delete();
    for (int i = 0; i < 400; i++) begin
      v = 1'($urandom_range(0, 1));
      drive(v, $urandom, ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
      @(negedge clk);
      n_tests++; if (bus.miss_ready_o !== exp_ready) begin n_fail++; $display("FAIL rand_ready i=%0d got %b exp %b", i, bus.miss_ready_o, exp_ready); end
      n_tests++; if (bus.miss_addr_fifo_wren_o !== (v && exp_ready)) begin n_fail++; $display("FAIL rand_wren i=%0d got %b exp %b", i, bus.miss_addr_fifo_wren_o, (v && exp_ready)); end
      n_tests++; if (bus.mem_arvalid_o !== m_pend) begin n_fail++; $display("FAIL rand_arvalid i=%0d got %b exp %b", i, bus.mem_arvalid_o, m_pend); end
      if (m_pend) begin
        n_tests++; if (bus.mem_araddr_o !== m_pend_addr) begin n_fail++; $display("FAIL rand_araddr i=%0d got %h exp %h", i, bus.mem_araddr_o, m_pend_addr); end
      end
      n_tests++; if (bus.busy_o !== (m_out != 0)) begin n_fail++; $display("FAIL rand_busy i=%0d got %b exp %b", i, bus.busy_o, (m_out != 0)); end
      next_cycle();
    end
    // Let any pending AR issue, then compare push and issue orders
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      next_cycle();
    end
    @(negedge clk);
    n_tests++;
    if (obs_push.size() != m_push_log.size() || obs_ar.size() != m_ar_log.size() || obs_ar.size() != obs_push.size()) begin
      n_fail++;
      $display("FAIL rand_counts got push %0d ar %0d exp push %0d ar %0d",
               obs_push.size(), obs_ar.size(), m_push_log.size(), m_ar_log.size());
    end
    n = obs_push.size();
    if (obs_ar.size() < n) n = obs_ar.size();
    if (m_push_log.size() < n) n = m_push_log.size();
    if (m_ar_log.size() < n) n = m_ar_log.size();
    for (int i = 0; i < n; i++) begin
      n_tests++; if (obs_push[i] !== m_push_log[i]) begin n_fail++; $display("FAIL rand_push_seq #%0d got %h exp %h", i, obs_push[i], m_push_log[i]); end
      n_tests++; if (obs_ar[i] !== m_ar_log[i]) begin n_fail++; $display("FAIL rand_ar_seq #%0d got %h exp %h", i, obs_ar[i], m_ar_log[i]); end
      n_tests++; if (obs_ar[i] !== (obs_push[i] & ~32'h7)) begin n_fail++; $display("FAIL rand_order #%0d got ar %h exp %h", i, obs_ar[i], obs_push[i] & ~32'h7); end
    end
    next_cycle();
    for (int i = 0; i < int'(MAX_OUT); i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      next_cycle();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_tests++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL rand_drained_busy got %b exp 0", bus.busy_o); end
    next_cycle();
  endtask

  initial begin
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_single_miss();
    test_back_to_back();
    test_fifo_full();
    test_reset_mid_burst();
    test_count_limit();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
